// File: rtl/uart_autobaud_if.sv
// uart_autobaud_if: serial line, receiver byte stream and status bundle for the autobaud controller
// Ports: rx_line (raw serial line), rx_data/rx_valid (receiver bytes), relock (restart request),
//        mode (baud code to receiver), locked (confirmed mode in use), fail (rejected attempt strobe)
interface uart_autobaud_if;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       relock;
    logic [3:0] mode;
    logic       locked;
    logic       fail;
    modport master (output rx_line, rx_data, rx_valid, relock, input mode, locked, fail);
    modport slave  (input rx_line, rx_data, rx_valid, relock, output mode, locked, fail);
endinterface

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync start bit, selects the receiver baud mode and confirms it
// Ports: clk (rising edge), rst_n (async active-low reset), bus (uart_autobaud_if.slave)
module uart_autobaud #(
    parameter int CLK_FREQ = 50000000,
    parameter int IDLE_MIN = 20834
) (
    input logic            clk,
    input logic            rst_n,
    uart_autobaud_if.slave bus
);
    typedef enum logic [2:0] {IDLE_WAIT, ARM, MEASURE, CONFIRM, LOCKED} state_t;
    function automatic logic [31:0] bit_len(input int baud);
        return 32'((CLK_FREQ + baud / 2) / baud);
    endfunction
    localparam logic [31:0] LEN [4] = '{bit_len(4800), bit_len(9600), bit_len(115200), bit_len(256000)};
    localparam logic [31:0] W_MAX = 32'd20834;
    state_t      state_q, state_d;
    logic        sync_q, s_q, p_q;
    logic [31:0] c_q, c_d, w_q, w_d;
    logic [1:0]  f_q, f_d;
    logic [3:0]  mode_q, mode_d;
    logic        locked_q, locked_d, fail_q, fail_d;
    logic        fall, hit;
    logic [3:0]  code;
    logic [31:0] tmo;
    assign fall = !s_q && p_q;
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        w_d     = w_q;
        f_d     = f_q;
        mode_d  = mode_q;
        fail_d  = 1'b0;
        hit     = 1'b0;
        code    = mode_q;
        tmo     = '0;
        // windows are L +/- L/8 and disjoint, so at most one matches
        for (int i = 0; i < 4; i++) begin
            if (w_q >= LEN[i] - (LEN[i] >> 3) && w_q <= LEN[i] + (LEN[i] >> 3)) begin
                hit  = 1'b1;
                code = 4'(i);
            end
            if (mode_q == 4'(i))
                tmo = LEN[i] << 5;
        end
        case (state_q)
            IDLE_WAIT: begin
                c_d = s_q ? c_q + 32'd1 : '0;
                if (c_d == 32'(IDLE_MIN))
                    state_d = ARM;
            end
            ARM: begin
                if (fall) begin
                    w_d     = 32'd1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!s_q) begin
                    w_d = w_q + 32'd1;
                    if (w_d == W_MAX) begin
                        fail_d  = 1'b1;
                        state_d = IDLE_WAIT;
                    end
                // s high here is always the rising edge: MEASURE is only entered on a low sample
                end else if (hit) begin
                    mode_d  = code;
                    c_d     = '0;
                    f_d     = '0;
                    state_d = CONFIRM;
                end else begin
                    fail_d  = 1'b1;
                    state_d = IDLE_WAIT;
                end
            end
            CONFIRM: begin
                c_d = c_q + 32'd1;
                if (bus.rx_valid && bus.rx_data == 8'h55)
                    state_d = LOCKED;
                else if ((bus.rx_valid && f_q == 2'd2) || c_d == tmo) begin
                    fail_d  = 1'b1;
                    state_d = IDLE_WAIT;
                end else if (bus.rx_valid)
                    f_d = f_q + 2'd1;
            end
            default: ;
        endcase
        if (bus.relock) begin
            state_d = IDLE_WAIT;
            fail_d  = 1'b0;
            mode_d  = mode_q;
        end
        if (bus.relock || (state_d == IDLE_WAIT && state_q != IDLE_WAIT)) begin
            c_d = '0;
            w_d = '0;
            f_d = '0;
        end
        locked_d = state_d == LOCKED;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b1;
            s_q      <= 1'b1;
            p_q      <= 1'b1;
            state_q  <= IDLE_WAIT;
            c_q      <= '0;
            w_q      <= '0;
            f_q      <= '0;
            mode_q   <= 4'd1;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            sync_q   <= bus.rx_line;
            s_q      <= sync_q;
            p_q      <= s_q;
            state_q  <= state_d;
            c_q      <= c_d;
            w_q      <= w_d;
            f_q      <= f_d;
            mode_q   <= mode_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end
    assign bus.mode   = mode_q;
    assign bus.locked = locked_q;
    assign bus.fail   = fail_q;
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: directed and randomized checks of uart_autobaud against a window-table model
module tb_uart_autobaud;
    localparam int IDLE = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    uart_autobaud_if bus();
    uart_autobaud #(.CLK_FREQ(50000000), .IDLE_MIN(IDLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // model: accepted low-pulse windows straight from the mode table; -1 means rejected
    function automatic int ref_mode(input int width);
        int lo [4] = '{9115, 4557, 380, 171};
        int hi [4] = '{11719, 5859, 488, 219};
        for (int i = 0; i < 4; i++)
            if (width >= lo[i] && width <= hi[i])
                return i;
        return -1;
    endfunction
    task automatic do_reset();
        bus.rx_line  = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.relock   = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask
    task automatic idle(input int n);
        bus.rx_line = 1'b1;
        repeat (n) tick();
    endtask
    task automatic pulse(input int n, output int fails, output int mode_after);
        fails = 0;
        bus.rx_line = 1'b0;
        repeat (n) begin
            tick();
            fails += int'(bus.fail);
        end
        bus.rx_line = 1'b1;
        repeat (6) begin
            tick();
            fails += int'(bus.fail);
        end
        mode_after = int'(bus.mode);
    endtask
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask
    initial begin
        int fails, m, k, w, e, nm, mode_exp;
        logic [7:0] b;
        do_reset();
        chk("reset_mode", 32'(bus.mode), 32'd1);
        chk("reset_locked", 32'(bus.locked), 32'd0);
        chk("reset_fail", 32'(bus.fail), 32'd0);
        // 434-cycle start bit then a matching sync byte
        idle(IDLE + 10);
        pulse(434, fails, m);
        chk("m2_fail", fails, 0);
        chk("m2_mode", m, 2);
        chk("m2_prelock", 32'(bus.locked), 32'd0);
        send(8'h55);
        chk("m2_locked", 32'(bus.locked), 32'd1);
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
        chk("relock_locked", 32'(bus.locked), 32'd0);
        chk("relock_mode", 32'(bus.mode), 32'd2);
        // asynchronous reset mid-measurement
        idle(IDLE + 10);
        bus.rx_line = 1'b0;
        repeat (100) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mode", 32'(bus.mode), 32'd1);
        chk("arst_locked", 32'(bus.locked), 32'd0);
        chk("arst_fail", 32'(bus.fail), 32'd0);
        do_reset();
        // window boundaries
        idle(IDLE + 10);
        pulse(9115, fails, m);
        chk("w9115_fail", fails, 0);
        chk("w9115_mode", m, 0);
        do_reset();
        idle(IDLE + 10);
        pulse(9114, fails, m);
        chk("w9114_fail", fails, 1);
        chk("w9114_mode", m, 1);
        idle(30);
        pulse(434, fails, m);
        chk("w9114_noarm_fail", fails, 0);
        chk("w9114_noarm_mode", m, 1);
        do_reset();
        idle(IDLE + 10);
        pulse(219, fails, m);
        chk("w219_fail", fails, 0);
        chk("w219_mode", m, 3);
        // line stuck low after arming
        do_reset();
        idle(IDLE + 10);
        pulse(21000, fails, m);
        chk("stuck_fail", fails, 1);
        chk("stuck_mode", m, 1);
        chk("stuck_locked", 32'(bus.locked), 32'd0);
        // three mis-framed bytes reject the attempt
        do_reset();
        idle(IDLE + 10);
        pulse(5208, fails, m);
        chk("m1_fail", fails, 0);
        chk("m1_mode", m, 1);
        send(8'hAA);
        chk("aa1_fail", 32'(bus.fail), 32'd0);
        send(8'hAA);
        chk("aa2_fail", 32'(bus.fail), 32'd0);
        send(8'hAA);
        chk("aa3_fail", 32'(bus.fail), 32'd1);
        chk("aa3_mode", 32'(bus.mode), 32'd1);
        tick();
        chk("aa3_fail_width", 32'(bus.fail), 32'd0);
        idle(30);
        pulse(434, fails, m);
        chk("aa_noarm_mode", m, 1);
        idle(IDLE + 10);
        pulse(434, fails, m);
        chk("aa_rearm_mode", m, 2);
        // relock beats a matching byte in the same cycle
        do_reset();
        idle(IDLE + 10);
        pulse(434, fails, m);
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        bus.relock   = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.relock   = 1'b0;
        chk("race_locked", 32'(bus.locked), 32'd0);
        send(8'h55);
        chk("race_ignored_valid", 32'(bus.locked), 32'd0);
        chk("race_mode", 32'(bus.mode), 32'd2);
        // confirm timeout: 32 bit times of 195 cycles
        do_reset();
        idle(IDLE + 10);
        bus.rx_line = 1'b0;
        repeat (195) tick();
        bus.rx_line = 1'b1;
        k = 0;
        while (bus.mode !== 4'd3 && k < 20) begin
            tick();
            k++;
        end
        chk("tmo_mode", 32'(bus.mode), 32'd3);
        k = 0;
        while (bus.fail !== 1'b1 && k < 7000) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, 6240);
        chk("tmo_mode_held", 32'(bus.mode), 32'd3);
        // randomized start-bit widths and confirm byte streams
        do_reset();
        mode_exp = 1;
        for (int it = 0; it < 12; it++) begin
            bus.relock = 1'b1;
            tick();
            bus.relock = 1'b0;
            idle(IDLE + 10);
            w = int'($urandom_range(150, 520));
            pulse(w, fails, m);
            e = ref_mode(w);
            if (e < 0) begin
                chk($sformatf("rnd%0d_w%0d_fail", it, w), fails, 1);
                chk($sformatf("rnd%0d_w%0d_mode", it, w), m, mode_exp);
            end else begin
                mode_exp = e;
                chk($sformatf("rnd%0d_w%0d_fail", it, w), fails, 0);
                chk($sformatf("rnd%0d_w%0d_mode", it, w), m, mode_exp);
                nm = int'($urandom_range(0, 3));
                for (int j = 0; j < nm; j++) begin
                    b = 8'($urandom);
                    if (b == 8'h55)
                        b = 8'h00;
                    send(b);
                end
                if (nm == 3)
                    chk($sformatf("rnd%0d_reject", it), 32'(bus.fail), 32'd1);
                else begin
                    send(8'h55);
                    chk($sformatf("rnd%0d_lock", it), 32'(bus.locked), 32'd1);
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Automatic baud-rate controller for the UART receive path. It watches the raw serial line, measures the start bit of a 0x55 sync character, and selects the matching 4-bit `mode` code for the receiver (0=4800, 1=9600, 2=115200, 3=256000 at 50 MHz). It then confirms the selection against the bytes the receiver delivers, and holds the mode until a relock is requested. It sits beside the receiver, drives its `mode` input, and consumes its `data`/`data_valid` outputs.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz. Bit lengths are fixed at 10417/5208/434/195 cycles for modes 0..3.
- `IDLE_MIN`, 20834: consecutive synchronized-high cycles required before arming.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_line`  in  1  raw serial line, asynchronous to `clk`.
- `rx_data`  in  8  byte from the receiver.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` is valid.
- `relock`  in  1  one-cycle request to restart detection.
- `mode`  out  4  baud code to the receiver.
- `locked`  out  1  high while a confirmed mode is in use.
- `fail`  out  1  one-cycle strobe: a detection attempt was rejected.

## Operation
- Input conditioning:
  - `rx_line` passes through a 2-flop synchronizer to give `s`.
  - `p` is `s` delayed by one cycle.
  - Falling edge: `s`=0 and `p`=1. Rising edge: `s`=1 and `p`=0.
- Reset state:
  - State is IDLE_WAIT with all counters at 0.
  - `mode`=4'd1, `locked`=0, `fail`=0.
  - Synchronizer flops reset to 1.
- IDLE_WAIT:
  - 32-bit counter `c` increments while `s`=1 and clears to 0 when `s`=0.
  - When `c` reaches `IDLE_MIN`, go to ARM.
- ARM: on a falling edge, set width counter `w`=1 and go to MEASURE.
- MEASURE:
  - While `s`=0, `w` increments by 1 per cycle. A low pulse of N cycles therefore ends with `w`=N.
  - If `w` reaches 20834 while `s` is still 0, assert `fail` and go to IDLE_WAIT.
  - On a rising edge, classify `w` against window [L-(L>>3), L+(L>>3)] inclusive for each mode:
    - mode 0: [9115, 11719]
    - mode 1: [4557, 5859]
    - mode 2: [380, 488]
    - mode 3: [171, 219]
  - The windows are disjoint. On a match, load `mode` with that code, clear `c` and the frame counter `f`, and go to CONFIRM.
  - With no match, assert `fail`, leave `mode` unchanged, and go to IDLE_WAIT.
- CONFIRM:
  - `c` counts cycles.
  - Each `rx_valid` with `rx_data`=8'h55 goes to LOCKED.
  - Each `rx_valid` with any other byte increments 2-bit `f`. The third such mismatch asserts `fail` and goes to IDLE_WAIT.
  - If `c` reaches 32×L of the selected mode before a match, assert `fail` and go to IDLE_WAIT.
- LOCKED: `locked`=1. `rx_line` and `rx_valid` are ignored.
- Common rules:
  - `relock` in any state goes to IDLE_WAIT, clears `locked` and the counters, and holds `mode`.
  - `relock` has priority over every other transition in the same cycle.
  - `mode` changes only on a successful classification or on reset. It is never left at an undefined code.

## Timing
- Synchronizer latency is 2 cycles from `rx_line` to `s`. Edge detection adds 1 cycle.
- `mode` updates on the clock edge that samples the rising edge. It is visible 1 cycle after `s` returns high.
- `locked` rises on the edge after the cycle carrying the matching `rx_valid`.
- `locked` falls on the edge after `relock`.
- `fail` is high for exactly 1 cycle, on the edge that leaves MEASURE or CONFIRM.
- A falling edge in IDLE_WAIT only clears `c`; it never starts a measurement.
- A `rx_valid` outside CONFIRM is ignored.
- Asserting reset mid-MEASURE or mid-CONFIRM restores the reset values immediately (asynchronously).
- The receiver may mis-frame the sync character during MEASURE. CONFIRM's 3-frame allowance exists to absorb this.

## Test plan
- Reset, hold the line high for 21000 cycles, drive a 434-cycle low, then pulse `rx_valid` with 8'h55: expect `mode`=2 one cycle after `s` rises, then `locked`=1 the cycle after the strobe.
- Window boundaries:
  - A 9115-cycle low gives `mode`=0 and no `fail`.
  - A 9114-cycle low gives a 1-cycle `fail`, `mode` held at 1, and a return to IDLE_WAIT.
  - A 219-cycle low gives `mode`=3.
- Line held low for more than 20834 cycles after arming: expect `fail` when `w` reaches 20834 and `locked`=0.
- After a 5208-cycle low, send three `rx_valid` strobes with 8'hAA: expect `fail` on the third strobe, `mode` still 1, and re-arming only after 20834 high cycles.
- In LOCKED with `mode`=2:
  - Pulse `relock`: expect `locked`=0 next cycle with `mode` still 2.
  - Then assert `rst_n` low mid-MEASURE: expect `mode`=1, `locked`=0, `fail`=0 immediately.
- Relock and CONFIRM timeout:
  - Fire `relock` in the same cycle as a matching `rx_valid` in CONFIRM: expect `locked` to stay 0.
  - After a 195-cycle low, send no `rx_valid`: expect `fail` 6240 cycles after entering CONFIRM.
